// File: rtl/acq_sequencer.sv
// Acquisition sequencer: turns on DAC playback, waits a settle delay, then runs
// N four-phase start/done capture handshakes with the ADC memory controller.
module acq_sequencer #(
  parameter int SETTLE_W = 16,
  parameter int RUNS_W   = 8,
  parameter int TO_W     = 24
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  input  logic [RUNS_W-1:0]   num_runs_i,
  input  logic [TO_W-1:0]     timeout_i,
  input  logic                adc_done_i,
  output logic                dac_en_o,
  output logic                adc_start_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_timeout_o,
  output logic                aborted_o,
  output logic [RUNS_W-1:0]   run_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ARM,
    S_WAIT_DONE,
    S_RELEASE,
    S_COMPLETE
  } state_t;

  localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
  localparam logic [RUNS_W-1:0]   RUNS_ONE   = RUNS_W'(1);
  localparam logic [TO_W-1:0]     TO_ONE     = TO_W'(1);

  state_t              r_state, w_state;
  logic                r_startQ;
  logic [SETTLE_W-1:0] r_cnt, w_cnt;
  logic [RUNS_W-1:0]   r_runs, w_runs;
  logic [TO_W-1:0]     r_timeout, w_timeout;
  logic [TO_W-1:0]     r_toCnt, w_toCnt;
  logic                r_dacEn, w_dacEn;
  logic                r_adcStart, w_adcStart;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_errTo, w_errTo;
  logic                r_aborted, w_aborted;
  logic [RUNS_W-1:0]   r_runCnt, w_runCnt;

  logic                w_startRise;
  logic                w_toHit;
  logic                w_fireTimeout;
  logic [TO_W-1:0]     w_toNext;

  assign w_startRise = start_i & ~r_startQ;
  assign w_toNext    = r_toCnt + TO_ONE;
  // A zero timeout value disables the check entirely.
  assign w_toHit     = (r_timeout != '0) && (w_toNext == r_timeout);

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_runs        = r_runs;
    w_timeout     = r_timeout;
    w_toCnt       = r_toCnt;
    w_dacEn       = r_dacEn;
    w_adcStart    = r_adcStart;
    w_done        = r_done;
    w_errTo       = r_errTo;
    w_aborted     = r_aborted;
    w_runCnt      = r_runCnt;
    w_fireTimeout = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_startRise) begin
          w_cnt     = settle_cycles_i;
          w_runs    = (num_runs_i == '0) ? RUNS_ONE : num_runs_i;
          w_timeout = timeout_i;
          w_done    = 1'b0;
          w_errTo   = 1'b0;
          w_aborted = 1'b0;
          w_runCnt  = '0;
          w_dacEn   = 1'b1;
          w_state   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state = S_ARM;
        end else begin
          w_cnt = r_cnt - SETTLE_ONE;
        end
      end
      S_ARM: begin
        w_adcStart = 1'b1;
        w_toCnt    = '0;
        w_state    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (adc_done_i) begin
          w_adcStart = 1'b0;
          w_runCnt   = (r_runCnt == '1) ? r_runCnt : r_runCnt + RUNS_ONE;
          w_toCnt    = '0;
          w_state    = S_RELEASE;
        end else if (w_toHit) begin
          w_fireTimeout = 1'b1;
        end else begin
          w_toCnt = w_toNext;
        end
      end
      S_RELEASE: begin
        // Further captures re-arm directly: the DAC stays on, no re-settle.
        if (!adc_done_i) begin
          w_state = (r_runCnt == r_runs) ? S_COMPLETE : S_ARM;
        end else if (w_toHit) begin
          w_fireTimeout = 1'b1;
        end else begin
          w_toCnt = w_toNext;
        end
      end
      S_COMPLETE: begin
        w_dacEn = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_fireTimeout) begin
      w_errTo    = 1'b1;
      w_dacEn    = 1'b0;
      w_adcStart = 1'b0;
      w_state    = S_IDLE;
    end

    // Abort overrides everything else once an acquisition is underway.
    if ((r_state != S_IDLE) && abort_i) begin
      w_state    = S_IDLE;
      w_dacEn    = 1'b0;
      w_adcStart = 1'b0;
      w_aborted  = 1'b1;
      w_done     = r_done;
      w_errTo    = r_errTo;
      w_runCnt   = r_runCnt;
    end

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_startQ   <= 1'b0;
      r_cnt      <= '0;
      r_runs     <= '0;
      r_timeout  <= '0;
      r_toCnt    <= '0;
      r_dacEn    <= 1'b0;
      r_adcStart <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_errTo    <= 1'b0;
      r_aborted  <= 1'b0;
      r_runCnt   <= '0;
    end else begin
      r_state    <= w_state;
      r_startQ   <= start_i;
      r_cnt      <= w_cnt;
      r_runs     <= w_runs;
      r_timeout  <= w_timeout;
      r_toCnt    <= w_toCnt;
      r_dacEn    <= w_dacEn;
      r_adcStart <= w_adcStart;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_errTo    <= w_errTo;
      r_aborted  <= w_aborted;
      r_runCnt   <= w_runCnt;
    end
  end

  assign dac_en_o      = r_dacEn;
  assign adc_start_o   = r_adcStart;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_timeout_o = r_errTo;
  assign aborted_o     = r_aborted;
  assign run_cnt_o     = r_runCnt;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: a behavioural ADC responder plus a
// scoreboard of expected run counts popped at every completed capture handshake.
module tb_acq_sequencer;

  logic        sys_clk;
  logic        sys_rst;
  logic        start_i;
  logic        abort_i;
  logic [15:0] settle_cycles_i;
  logic [7:0]  num_runs_i;
  logic [23:0] timeout_i;
  logic        adc_done_i;
  logic        dac_en_o;
  logic        adc_start_o;
  logic        busy_o;
  logic        done_o;
  logic        err_timeout_o;
  logic        aborted_o;
  logic [7:0]  run_cnt_o;

  int checks = 0;
  int errors = 0;
  int expRunQ[$];

  bit adcAuto;
  int riseDelay;
  int fallDelay;
  int hiCnt;
  int loCnt;

  int mRise[$];
  int mFall[$];
  int mHigh[$];
  int mLow[$];
  int mDacCyc;
  int mDoneCyc;
  int mDacGap;

  acq_sequencer #(.SETTLE_W(16), .RUNS_W(8), .TO_W(24)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .settle_cycles_i (settle_cycles_i),
    .num_runs_i      (num_runs_i),
    .timeout_i       (timeout_i),
    .adc_done_i      (adc_done_i),
    .dac_en_o        (dac_en_o),
    .adc_start_o     (adc_start_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_timeout_o   (err_timeout_o),
    .aborted_o       (aborted_o),
    .run_cnt_o       (run_cnt_o)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ADC controller model: done rises riseDelay cycles after start rises and
  // falls fallDelay cycles after start falls; updated just after each edge.
  initial begin
    adc_done_i = 1'b0;
    hiCnt = 0;
    loCnt = 0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (!adcAuto) begin
        adc_done_i = 1'b0;
        hiCnt = 0;
        loCnt = 0;
      end else if (adc_start_o && !adc_done_i) begin
        loCnt = 0;
        if (hiCnt >= riseDelay) adc_done_i = 1'b1;
        else hiCnt++;
      end else if (!adc_start_o && adc_done_i) begin
        hiCnt = 0;
        if (loCnt >= fallDelay) adc_done_i = 1'b0;
        else loCnt++;
      end else begin
        hiCnt = 0;
        loCnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(negedge sys_clk);
  endtask

  task automatic start_acq(input int s, input int runs, input int to, input int nPush);
    settle_cycles_i = 16'(s);
    num_runs_i      = 8'(runs);
    timeout_i       = 24'(to);
    for (int i = 1; i <= nPush; i++) expRunQ.push_back(i);
    start_i = 1'b1;
  endtask

  // Observes one acquisition from the cycle start_i was raised; cycle c is the
  // c-th falling edge after that. Pops the scoreboard at each capture release.
  task automatic run_acq(input int budget, input int holdCyc, input int reRiseCyc, input bit swapCfg);
    int c;
    int exp;
    bit fin;
    logic pStart;
    logic pDone;
    mRise.delete(); mFall.delete(); mHigh.delete(); mLow.delete();
    mDacCyc = -1; mDoneCyc = -1; mDacGap = 0;
    pStart = adc_start_o; pDone = adc_done_i;
    c = 0; fin = 0;
    while (!fin) begin
      tick;
      c++;
      if (c == holdCyc) start_i = 1'b0;
      if (reRiseCyc > 0 && c == reRiseCyc) start_i = 1'b1;
      if (reRiseCyc > 0 && c == reRiseCyc + 1) start_i = 1'b0;
      if (swapCfg && c == 2) begin
        settle_cycles_i = 16'd20;
        num_runs_i      = 8'd3;
        timeout_i       = 24'd3;
      end
      if (mDacCyc < 0 && dac_en_o) mDacCyc = c;
      if (adc_start_o && !pStart) mRise.push_back(c);
      if (!adc_start_o && pStart) begin
        mFall.push_back(c);
        if (!err_timeout_o && !aborted_o) begin
          checks++;
          if (expRunQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_run_cnt: got unexpected capture, run_cnt=%0d, required none", run_cnt_o);
          end else begin
            exp = expRunQ.pop_front();
            if (run_cnt_o !== 8'(exp)) begin
              errors++;
              $display("[TB] FAIL sb_run_cnt: got %0d, required %0d", run_cnt_o, exp);
            end
          end
        end
      end
      if (adc_done_i && !pDone) mHigh.push_back(c);
      if (!adc_done_i && pDone) mLow.push_back(c);
      if (mDoneCyc < 0 && done_o) mDoneCyc = c;
      if (busy_o && !dac_en_o) mDacGap++;
      pStart = adc_start_o;
      pDone  = adc_done_i;
      if (c > 1 && !busy_o) fin = 1;
      else if (c >= budget) begin
        checks++; errors++;
        $display("[TB] FAIL acq_bound: still busy after %0d cycles, required idle", c);
        fin = 1;
      end
    end
    start_i = 1'b0;
    checks++;
    if (expRunQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d pending captures, required 0", expRunQ.size());
      expRunQ.delete();
    end
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({dac_en_o, adc_start_o, busy_o, done_o, err_timeout_o, aborted_o, run_cnt_o} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, required all 0",
               {dac_en_o, adc_start_o, busy_o, done_o, err_timeout_o, aborted_o, run_cnt_o});
    end
    sys_rst = 1'b0;
    repeat (2) tick;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: busy got %b, required 0", busy_o);
    end
  endtask

  task automatic test_single;
    $display("[TB] single capture, S=3");
    start_acq(3, 1, 0, 1);
    run_acq(100, 1, 0, 0);
    checks++;
    if (mDacCyc !== 1) begin
      errors++; $display("[TB] FAIL single_dac_rise: got cycle %0d, required 1", mDacCyc);
    end
    checks++;
    if (mRise.size() !== 1 || mRise[0] !== 6) begin
      errors++; $display("[TB] FAIL single_start_rise: got %0d rises first at %0d, required 1 at 6", mRise.size(), mRise[0]);
    end
    // done high is seen one cycle before the DUT samples it; start drops one after.
    checks++;
    if (mFall[0] !== mHigh[0] + 1) begin
      errors++; $display("[TB] FAIL single_start_fall: got cycle %0d, required %0d", mFall[0], mHigh[0] + 1);
    end
    // done low is sampled at the next edge (to COMPLETE), done_o one cycle later.
    checks++;
    if (mDoneCyc !== mLow[0] + 2) begin
      errors++; $display("[TB] FAIL single_done_time: got cycle %0d, required %0d", mDoneCyc, mLow[0] + 2);
    end
    checks++;
    if (done_o !== 1'b1 || dac_en_o !== 1'b0 || run_cnt_o !== 8'd1) begin
      errors++; $display("[TB] FAIL single_final: got done=%b dac=%b cnt=%0d, required 1 0 1", done_o, dac_en_o, run_cnt_o);
    end
  endtask

  task automatic test_multi_run;
    $display("[TB] three captures, S=0");
    start_acq(0, 3, 0, 3);
    run_acq(200, 1, 0, 0);
    checks++;
    if (mRise.size() !== 3 || mRise[0] !== 3) begin
      errors++; $display("[TB] FAIL multi_rises: got %0d rises first at %0d, required 3 at 3", mRise.size(), mRise[0]);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (mRise[i] !== mLow[i-1] + 2) begin
        errors++; $display("[TB] FAIL multi_rearm_%0d: got cycle %0d, required %0d", i, mRise[i], mLow[i-1] + 2);
      end
    end
    checks++;
    if (mDacGap !== 0) begin
      errors++; $display("[TB] FAIL multi_dac_gap: got %0d busy cycles with dac off, required 0", mDacGap);
    end
    checks++;
    if (mDoneCyc !== mLow[2] + 2 || run_cnt_o !== 8'd3) begin
      errors++; $display("[TB] FAIL multi_done: got cycle %0d cnt %0d, required %0d cnt 3", mDoneCyc, run_cnt_o, mLow[2] + 2);
    end
  endtask

  task automatic test_zero_runs;
    $display("[TB] zero runs treated as one");
    start_acq(1, 0, 0, 1);
    run_acq(100, 1, 0, 0);
    checks++;
    if (mRise.size() !== 1 || done_o !== 1'b1 || run_cnt_o !== 8'd1) begin
      errors++; $display("[TB] FAIL zero_runs: got rises=%0d done=%b cnt=%0d, required 1 1 1", mRise.size(), done_o, run_cnt_o);
    end
  endtask

  task automatic test_timeout;
    $display("[TB] timeout=10 with done stuck low");
    adcAuto = 1'b0;
    start_acq(2, 1, 10, 0);
    run_acq(100, 1, 0, 0);
    checks++;
    if (mRise.size() !== 1 || mRise[0] !== 5) begin
      errors++; $display("[TB] FAIL to_start_rise: got %0d rises first at %0d, required 1 at 5", mRise.size(), mRise[0]);
    end
    checks++;
    if (mFall[0] - mRise[0] !== 10) begin
      errors++; $display("[TB] FAIL to_latency: got %0d cycles in WAIT_DONE, required 10", mFall[0] - mRise[0]);
    end
    checks++;
    if (err_timeout_o !== 1'b1 || adc_start_o !== 1'b0 || dac_en_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL to_flags: got err=%b start=%b dac=%b done=%b busy=%b, required 1 0 0 0 0",
                         err_timeout_o, adc_start_o, dac_en_o, done_o, busy_o);
    end
    adcAuto = 1'b1;
  endtask

  task automatic test_abort;
    int c;
    int rises;
    int exp;
    logic pS;
    $display("[TB] abort during run 2 of 4");
    start_acq(2, 4, 0, 1);
    c = 0; rises = 0; pS = adc_start_o;
    while (rises < 2 && c < 200) begin
      tick;
      c++;
      if (c == 1) start_i = 1'b0;
      if (adc_start_o && !pS) rises++;
      if (!adc_start_o && pS) begin
        checks++;
        exp = (expRunQ.size() != 0) ? expRunQ.pop_front() : -1;
        if (run_cnt_o !== 8'(exp)) begin
          errors++; $display("[TB] FAIL abort_sb_run_cnt: got %0d, required %0d", run_cnt_o, exp);
        end
      end
      pS = adc_start_o;
    end
    if (rises < 2) begin
      checks++; errors++;
      $display("[TB] FAIL abort_bound: got %0d start rises, required 2", rises);
    end
    abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || aborted_o !== 1'b1 || run_cnt_o !== 8'd1 || dac_en_o !== 1'b0 || adc_start_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_state: got busy=%b ab=%b cnt=%0d dac=%b start=%b done=%b, required 0 1 1 0 0 0",
                         busy_o, aborted_o, run_cnt_o, dac_en_o, adc_start_o, done_o);
    end
    expRunQ.delete();
    repeat (8) tick;
    start_acq(0, 1, 0, 1);
    run_acq(100, 1, 0, 0);
    checks++;
    if (aborted_o !== 1'b0 || done_o !== 1'b1 || run_cnt_o !== 8'd1) begin
      errors++; $display("[TB] FAIL abort_restart: got ab=%b done=%b cnt=%0d, required 0 1 1", aborted_o, done_o, run_cnt_o);
    end
  endtask

  task automatic test_start_held;
    $display("[TB] start held high plus a second edge while busy");
    start_acq(150, 1, 0, 1);
    run_acq(400, 100, 110, 1);
    checks++;
    if (mRise.size() !== 1 || mRise[0] !== 153) begin
      errors++; $display("[TB] FAIL held_rises: got %0d rises first at %0d, required 1 at 153", mRise.size(), mRise[0]);
    end
    checks++;
    if (done_o !== 1'b1 || err_timeout_o !== 1'b0 || run_cnt_o !== 8'd1) begin
      errors++; $display("[TB] FAIL held_final: got done=%b err=%b cnt=%0d, required 1 0 1", done_o, err_timeout_o, run_cnt_o);
    end
    repeat (5) tick;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL held_no_retrigger: busy got %b, required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid;
    $display("[TB] reset during SETTLE");
    start_acq(50, 1, 0, 0);
    tick;
    start_i = 1'b0;
    repeat (2) tick;
    checks++;
    if (busy_o !== 1'b1 || dac_en_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_mid_pre: got busy=%b dac=%b, required 1 1", busy_o, dac_en_o);
    end
    sys_rst = 1'b1;
    tick;
    checks++;
    if ({dac_en_o, adc_start_o, busy_o, done_o, err_timeout_o, aborted_o, run_cnt_o} !== 14'd0) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: got %b, required all 0",
                         {dac_en_o, adc_start_o, busy_o, done_o, err_timeout_o, aborted_o, run_cnt_o});
    end
    sys_rst = 1'b0;
    repeat (3) tick;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_idle: busy got %b, required 0", busy_o);
    end
  endtask

  initial begin
    sys_rst         = 1'b1;
    start_i         = 1'b0;
    abort_i         = 1'b0;
    settle_cycles_i = '0;
    num_runs_i      = '0;
    timeout_i       = '0;
    adcAuto         = 1'b1;
    riseDelay       = 5;
    fallDelay       = 2;
    test_reset;
    test_single;
    test_multi_run;
    test_zero_runs;
    test_timeout;
    test_abort;
    test_start_held;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
